// File: rtl/pwm_bank_pkg.sv
// ---------------------------------------------------------------------------
// pwm_bank_pkg : shared sizes, address map limit and duty type for pwm_bank
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pwm_bank_pkg;

  localparam int          NUM_CH        = 8;
  localparam int          DUTY_W        = 16;
  localparam logic [15:0] CNT_MAX       = 16'hFFFF;
  localparam logic [7:0]  REG_LAST_ADDR = 8'h0F;

  typedef logic [DUTY_W-1:0] duty_t;

  function automatic logic addr_is_duty(input logic [7:0] addr);
    return addr <= REG_LAST_ADDR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_bank_chan.sv
// ---------------------------------------------------------------------------
// pwm_bank_chan : one PWM channel with byte staging, atomic commit, comparator
// Optional: PWM_BANK_SYNC_UPDATE_EN selects period-boundary duty updates.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_bank_chan
  import pwm_bank_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       lo_we_i,
  input  logic       hi_we_i,
  input  logic [7:0] data_i,
  input  duty_t      cnt_i,
  input  logic       wrap_i,
  input  logic       en_i,
  output duty_t      duty_pend_o,
  output logic       pwm_o
);

  logic [7:0] lo_hold_q;
  duty_t      duty_pend_q;
  duty_t      duty_cmp;
  logic       pwm_q;

  // The high-byte write pairs with the staged low byte, so software only
  // ever exposes a complete 16-bit value to the comparator.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lo_hold_q   <= 8'h00;
      duty_pend_q <= '0;
    end else begin
      if (lo_we_i) lo_hold_q   <= data_i;
      if (hi_we_i) duty_pend_q <= {data_i, lo_hold_q};
    end
  end

`ifdef PWM_BANK_SYNC_UPDATE_EN
  duty_t duty_act_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      duty_act_q <= '0;
    end else if (!en_i || wrap_i) begin
      duty_act_q <= duty_pend_q;
    end
  end

  assign duty_cmp = duty_act_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_i;
  assign duty_cmp    = duty_pend_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= en_i && (cnt_i < duty_cmp);
    end
  end

  assign duty_pend_o = duty_pend_q;
  assign pwm_o       = pwm_q;

endmodule

`default_nettype wire

// File: rtl/pwm_bank.sv
// ---------------------------------------------------------------------------
// pwm_bank : eight-channel PWM bank fed by the byte-wide I2C register bus
// Optional: PWM_BANK_SYNC_UPDATE_EN selects period-boundary duty updates.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       Clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       WEn,
  input  logic [7:0] Addr,
  input  logic [7:0] Out,
  output logic [7:0] rd_data,
  output logic [7:0] pwm_out,
  output logic       frame_start
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt_q, pre_cnt_d;
  duty_t       cnt_q, cnt_d;
  logic        frame_start_q;
  logic        tick;
  logic        wrap;

  logic              addr_hit;
  logic [2:0]        ch_sel;
  logic [NUM_CH-1:0] lo_we;
  logic [NUM_CH-1:0] hi_we;
  duty_t             duty_pend [NUM_CH];

  assign tick = en && (pre_cnt_q == PRE_LAST);
  assign wrap = tick && (cnt_q == CNT_MAX);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    if (!en) begin
      pre_cnt_d = 16'h0000;
      cnt_d     = '0;
    end else if (tick) begin
      pre_cnt_d = 16'h0000;
      cnt_d     = cnt_q + 16'h0001;
    end else begin
      pre_cnt_d = pre_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      pre_cnt_q     <= 16'h0000;
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      frame_start_q <= wrap;
    end
  end

  assign addr_hit = addr_is_duty(Addr);
  assign ch_sel   = Addr[3:1];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign lo_we[gi] = WEn && addr_hit && !Addr[0] && (ch_sel == 3'(gi));
      assign hi_we[gi] = WEn && addr_hit &&  Addr[0] && (ch_sel == 3'(gi));

      pwm_bank_chan u_chan (
        .clk_i       (Clk),
        .rst_ni      (rst_n),
        .lo_we_i     (lo_we[gi]),
        .hi_we_i     (hi_we[gi]),
        .data_i      (Out),
        .cnt_i       (cnt_q),
        .wrap_i      (wrap),
        .en_i        (en),
        .duty_pend_o (duty_pend[gi]),
        .pwm_o       (pwm_out[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_data = 8'h00;
    if (addr_hit) begin
      rd_data = Addr[0] ? duty_pend[ch_sel][15:8] : duty_pend[ch_sel][7:0];
    end
  end

  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_bank : directed + randomized bench for pwm_bank against a tick-count model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_bank;

  localparam int P      = 1;
  localparam int PERIOD = 65536 * P;

  logic       Clk = 1'b0;
  logic       rst_n, en, WEn;
  logic [7:0] Addr, Out;
  logic [7:0] rd_data, pwm_out;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  pwm_bank #(.PRESCALE(P)) dut (
    .Clk         (Clk),
    .rst_n       (rst_n),
    .en          (en),
    .WEn         (WEn),
    .Addr        (Addr),
    .Out         (Out),
    .rd_data     (rd_data),
    .pwm_out     (pwm_out),
    .frame_start (frame_start)
  );

  always #5 Clk = ~Clk;

  // Reference state: n counts enabled clock edges since reset or en rising
  int          m_n;
  logic [7:0]  m_lo   [8];
  logic [15:0] m_pend [8];
  logic [15:0] m_act  [8];
  logic [7:0]  m_pwm;
  logic        m_fs;

  task automatic model_step(input logic r, input logic e, input logic w,
                            input logic [7:0] a, input logic [7:0] d);
    int          k;
    int          cnt_before;
    logic [15:0] duty;
    bit          wrap;
    if (!r) begin
      m_n = 0; m_pwm = 8'h00; m_fs = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_lo[i] = 8'h00; m_pend[i] = 16'h0000; m_act[i] = 16'h0000;
      end
      return;
    end
    if (!e) begin
      m_n = 0; m_pwm = 8'h00; m_fs = 1'b0;
      for (int i = 0; i < 8; i++) m_act[i] = m_pend[i];
    end else begin
      k          = m_n + 1;
      cnt_before = (m_n / P) % 65536;
      wrap       = (k % PERIOD) == 0;
      for (int i = 0; i < 8; i++) begin
`ifdef PWM_BANK_SYNC_UPDATE_EN
        duty = m_act[i];
`else
        duty = m_pend[i];
`endif
        m_pwm[i] = (cnt_before < int'(duty));
      end
      m_fs = wrap;
      if (wrap) for (int i = 0; i < 8; i++) m_act[i] = m_pend[i];
      m_n = k;
    end
    if (w && a < 8'h10) begin
      if (a[0] == 1'b0) m_lo[a[3:1]] = d;
      else              m_pend[a[3:1]] = {d, m_lo[a[3:1]]};
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    if (a >= 8'h10) return 8'h00;
    return a[0] ? m_pend[a[3:1]][15:8] : m_pend[a[3:1]][7:0];
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h n=%0d", tag, obs, exp, m_n);
    end
  endtask

  task automatic cycle();
    logic       r, e, w;
    logic [7:0] a, d;
    r = rst_n; e = en; w = WEn; a = Addr; d = Out;
    @(posedge Clk);
    #1;
    model_step(r, e, w, a, d);
    check8("pwm_out", pwm_out, m_pwm);
    check8("frame_start", {7'b0, frame_start}, {7'b0, m_fs});
    check8("rd_data", rd_data, exp_rd(Addr));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    WEn = 1'b1; Addr = a; Out = d;
    cycle();
    WEn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rand_cycle(input bit allow_ch7);
    logic [7:0] a;
    a = 8'($urandom_range(0, 19));
    if (!allow_ch7 && (a == 8'h0E || a == 8'h0F)) a = 8'h11;
    if ($urandom_range(0, 7) == 0) wr(a, 8'($urandom));
    else begin
      Addr = a;
      cycle();
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; en = 1'b0; WEn = 1'b0; Addr = 8'h00; Out = 8'h00;
    idle(3);

    // Readback of every address out of reset, counter idle
    rst_n = 1'b1;
    for (int a = 0; a < 20; a++) begin
      Addr = 8'(a);
      cycle();
    end

    // ch2 = 0x0100, then staged-but-uncommitted low byte on ch0
    en = 1'b1;
    wr(8'h04, 8'h00);
    wr(8'h05, 8'h01);
    Addr = 8'h05; cycle();
    wr(8'h00, 8'hAA);
    Addr = 8'h00; idle(300);
    wr(8'h01, 8'h00);
    Addr = 8'h00; idle(20);

    // Randomized bus traffic including out-of-range writes
    for (int i = 0; i < 1500; i++) rand_cycle(1'b1);

    // en low mid-period, program ch1 = 0x8000, resume
    en = 1'b0;
    idle(3);
    wr(8'h02, 8'h00);
    wr(8'h03, 8'h80);
    idle(2);
    en = 1'b1;
    Addr = 8'h03; idle(400);

    // Synchronous reset mid-period, then writes to the LED address
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'h10, 8'($urandom));
    Addr = 8'h00; idle(2);

    // Random small duties, ch7 low byte staged for the wrap-cycle commit
    for (int c = 0; c < 7; c++) begin
      wr(8'(2 * c), 8'($urandom));
      wr(8'(2 * c + 1), 8'($urandom_range(0, 1)));
    end
    wr(8'h0E, 8'hFF);

    guard = 0;
    while (m_n != PERIOD - 1 && guard < 70000) begin
      if ($urandom_range(0, 999) == 0) rand_cycle(1'b0);
      else begin
        Addr = 8'($urandom_range(0, 19));
        cycle();
      end
      guard++;
    end
    checks++;
    assert (guard < 70000) else begin
      errors++;
      $error("FAIL wrap_reach observed=%0d expected=%0d", m_n, PERIOD - 1);
    end

    // High-byte commit of 0xFFFF lands on the wrap edge
    wr(8'h0F, 8'hFF);
    Addr = 8'h0F; idle(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_bank.md
# pwm_bank

Eight-channel PWM generator that sits directly downstream of the I2C register map. It uses the same byte-wide write bus (Addr/Out/WEn) to stage 16-bit duty values and drives the eight Port0 pins. Byte writes are assembled into coherent 16-bit duty words, and updates are applied glitch-free at period boundaries. A single free-running 16-bit counter with a prescaler is shared by all channels.

## Interface
- PRESCALE, default 1: Clk cycles per counter tick; legal range 1..65535.
- Clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  run enable; low holds the counter at 0 and forces outputs low.
- WEn  in  1  one-cycle write strobe from the I2C slave.
- Addr  in  8  byte address; 0x00–0x0F select channel Addr[3:1], and Addr[0] selects the low (0) or high (1) byte.
- Out  in  8  write data byte.
- rd_data  out  8  combinational readback of the pending duty byte at Addr; 0x00 when Addr ≥ 0x10.
- pwm_out  out  8  registered PWM outputs, one bit per channel; drives Port0.
- frame_start  out  1  one-Clk pulse when the counter wraps to 0.

## Operation
- Per-channel registers:
  - lo_hold[7:0] is the staging byte.
  - duty_pend[15:0] is the committed value.
  - duty_act[15:0] is the value the comparator uses.
- Low-byte write (WEn, Addr even, < 0x10): lo_hold[ch] <= Out. duty_pend is unchanged.
- High-byte write (WEn, Addr odd, < 0x10): duty_pend[ch] <= {Out, lo_hold[ch]}. A 16-bit value is only ever committed atomically.
- Writes with Addr ≥ 0x10 are ignored; the LED register at 0x10 is owned elsewhere.
- Readback: rd_data returns duty_pend[Addr[3:1]] low byte for even Addr and high byte for odd Addr. lo_hold is not readable.
- Prescaler: pre_cnt counts 0..PRESCALE-1. tick is asserted when pre_cnt == PRESCALE-1 and en = 1.
- Counter: on tick, cnt <= cnt + 1 modulo 2^16. The period is 65536 × PRESCALE Clk cycles.
- Wrap: wrap = tick && cnt == 0xFFFF. On wrap, frame_start <= 1 (otherwise 0) and duty_act <= duty_pend (subject to Configuration).
- Compare: pwm_out[i] <= en && (cnt < duty_act[i]), unsigned 16-bit.
  - Duty 0x0000 gives a constantly low output.
  - Duty 0xFFFF gives 65535 of 65536 ticks high; 100% duty is not representable.
- en low: pre_cnt and cnt are held at 0, pwm_out is 0, frame_start is 0, and duty_act <= duty_pend every cycle. Writes are still accepted.
- en rising: counting starts from cnt = 0 with no frame_start pulse for that first period.

## Timing
- Reset (rst_n = 0 at a Clk edge) clears the following to 0: pre_cnt, cnt, all lo_hold, duty_pend and duty_act, pwm_out, and frame_start. rd_data therefore reads 0x00.
- Reset mid-period takes effect at the next edge; there is no partial-period completion.
- pwm_out lags cnt by one Clk; frame_start is aligned with the edge where cnt becomes 0.
- Commit latency is one Clk: a high-byte write in cycle N is visible on rd_data in cycle N+1.
- A high-byte commit in the same cycle as wrap:
  - duty_act loads the pre-commit duty_pend.
  - The new value applies at the following wrap.
- Repeated low-byte writes overwrite lo_hold; only the last one is committed.
- A high-byte write with no prior low write since reset commits lo_hold = 0x00.

## Configuration
- PWM_BANK_SYNC_UPDATE_EN defined: duty_act loads only on wrap or while en = 0, as described above.
- Not defined: duty_act is removed and the comparator uses duty_pend directly. A committed change affects pwm_out two Clk after the high-byte write, mid-period; glitches are accepted.

## Structure
- Package pwm_bank_pkg holds:
  - NUM_CH = 8, DUTY_W = 16, and CNT_MAX = 16'hFFFF.
  - REG_LAST_ADDR = 8'h0F.
  - A typedef duty_t for the 16-bit duty value.
- Sub-module pwm_bank_chan, instantiated 8×, contains lo_hold, duty_pend, duty_act and the comparator. Its inputs are a decoded lo_we, hi_we, data byte, cnt, wrap and en.
- The top level contains the prescaler, counter, write decode and readback mux.

## Test plan
- Reset with no writes, en = 1, PRESCALE = 1, running 70000 cycles → pwm_out = 0x00 throughout, frame_start pulses at cycle 65536 after reset release, and rd_data = 0x00 at every address.
- Write 0x00 to Addr 0x04, then 0x01 to Addr 0x05 → rd_data reads 0x01 at Addr 0x05. pwm_out[2] stays low until the next wrap, then is high for 256 cycles per 65536-cycle period.
- Write only the low byte 0xAA to Addr 0x00 → duty_pend[0] is unchanged (rd_data 0x00) and pwm_out[0] is unaffected. A subsequent 0x00 written to Addr 0x01 commits 0x00AA.
- Commit duty 0xFFFF on ch7 in the exact wrap cycle with SYNC_EN defined → the old duty applies for one more period. pwm_out[7] is then low only 1 cycle per period.
- Drop en mid-period, write ch1 = 0x8000, then raise en → pwm_out is 0 while en is low. After en rises, pwm_out[1] is high for cycles 0–32767 of the first period.
- Assert rst_n low mid-period with duties nonzero → the next cycle shows all outputs 0, cnt 0 and all duty registers 0. Addr 0x10 writes never alter any channel.
